// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the instruction register and its controller.
package instr_register_pkg;
    localparam int DEPTH = 32;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0] address_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;
    typedef enum logic {INIT, RUN} ctrl_state_t;
endpackage

// File: rtl/instr_register_ctrl_if.sv
// instr_register_ctrl_if: producer push channel, consumer pop channel and occupancy status.
interface instr_register_ctrl_if;
    import instr_register_pkg::*;
    logic         wr_valid, wr_ready;
    opcode_t      wr_opcode;
    operand_t     wr_op_a, wr_op_b;
    logic         rd_req, rd_valid, rd_err;
    instruction_t rd_data;
    logic         flush, full, empty;
    logic [5:0]   count;
    modport master (
        output wr_valid, wr_opcode, wr_op_a, wr_op_b, rd_req, flush,
        input  wr_ready, rd_valid, rd_data, rd_err, count, full, empty
    );
    modport slave (
        input  wr_valid, wr_opcode, wr_op_a, wr_op_b, rd_req, flush,
        output wr_ready, rd_valid, rd_data, rd_err, count, full, empty
    );
endinterface

// File: rtl/instr_reg_occupancy.sv
// instr_reg_occupancy: circular-queue head/tail/count bookkeeping with one write in flight.
module instr_reg_occupancy
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    output address_t   head,
    output address_t   tail,
    output logic [5:0] count,
    output logic       pending,
    output logic       full,
    output logic       empty,
    output logic       has_room
);
    logic [6:0] used;
    // an accepted write occupies a slot from acceptance, before it commits
    assign used = {1'b0, count} + 7'(pending);
    assign full = used == 7'(DEPTH);
    assign has_room = used < 7'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset || clear) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            pending <= 1'b0;
        end else begin
            head <= head + address_t'(pop);
            tail <= tail + address_t'(push);
            count <= count + 6'(pending) - 6'(pop);
            pending <= push;
        end
endmodule

// File: rtl/instr_register_ctrl.sv
// instr_register_ctrl: sequences the instruction register as a FIFO, owning its reset, load and pointers.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int INIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_register_ctrl_if.slave  bus,
    output logic                  reg_reset_n,
    output logic                  load_en,
    output opcode_t               opcode,
    output operand_t              operand_a,
    output operand_t              operand_b,
    output address_t              write_pointer,
    output address_t              read_pointer,
    input  instruction_t          instruction_word
);
    ctrl_state_t state;
    logic [7:0]  init_cnt;
    logic        clear, push, pop, pending, has_room;
    address_t    head, tail;
    assign clear = state == RUN && bus.flush;
    assign bus.wr_ready = state == RUN && !bus.flush && has_room;
    assign push = bus.wr_valid && bus.wr_ready;
    assign pop = state == RUN && !bus.flush && bus.rd_req && !bus.empty;
    // the register read is combinational from read_pointer, so data follows the registered pointer
    assign bus.rd_data = bus.rd_valid ? instruction_word : '0;
    instr_reg_occupancy #(.DEPTH(DEPTH)) occ (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .push(push),
        .pop(pop),
        .head(head),
        .tail(tail),
        .count(bus.count),
        .pending(pending),
        .full(bus.full),
        .empty(bus.empty),
        .has_room(has_room)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= INIT;
            init_cnt <= '0;
            reg_reset_n <= 1'b0;
            load_en <= 1'b0;
            opcode <= ZERO;
            operand_a <= '0;
            operand_b <= '0;
            write_pointer <= '0;
            read_pointer <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err <= 1'b0;
        end else begin
            load_en <= push;
            bus.rd_valid <= pop;
            bus.rd_err <= bus.rd_req && !pop && !clear;
            if (push) begin
                opcode <= bus.wr_opcode;
                operand_a <= bus.wr_op_a;
                operand_b <= bus.wr_op_b;
                write_pointer <= tail;
            end
            if (pop) read_pointer <= head;
            if (state == INIT) begin
                if (init_cnt == 8'(INIT_CYCLES - 1)) begin
                    state <= RUN;
                    reg_reset_n <= 1'b1;
                end else
                    init_cnt <= init_cnt + 8'd1;
            end else if (clear) begin
                state <= INIT;
                init_cnt <= '0;
                reg_reset_n <= 1'b0;
                write_pointer <= '0;
                read_pointer <= '0;
            end
        end
endmodule

// File: tb/tb_instr_register_ctrl.sv
// tb_instr_register_ctrl: random and directed push/pop/flush traffic against a queue-level reference model.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;
    logic         clk = 1'b0, reset = 1'b0;
    logic         reg_reset_n, load_en;
    opcode_t      opcode;
    operand_t     operand_a, operand_b;
    address_t     write_pointer, read_pointer;
    instruction_t instruction_word;
    instruction_t mem [DEPTH];
    int checks = 0, errors = 0;

    instr_register_ctrl_if bus();
    instr_register_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .reg_reset_n(reg_reset_n),
        .load_en(load_en),
        .opcode(opcode),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .write_pointer(write_pointer),
        .read_pointer(read_pointer),
        .instruction_word(instruction_word)
    );

    always #5 clk = ~clk;

    function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
        case (o)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            default: return '0;
        endcase
    endfunction

    // stand-in for the instr_register datapath
    always @(posedge clk or negedge reg_reset_n)
        if (!reg_reset_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (load_en) mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                                                   result: calc(opcode, operand_a, operand_b)};
    assign instruction_word = mem[read_pointer];

    task automatic chk(string n, logic [135:0] got, logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // reference model: committed entries, the one write in flight, and popped-but-unseen results
    bit           running = 0, pend = 0, exp_rv = 0, exp_err = 0;
    int           init_left = 2, head_m = 0, tail_m = 0;
    instruction_t exp_q[$], sb_q[$], pend_item;
    address_t     exp_wp = '0, exp_rp = '0;

    initial begin
        bit acc;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                running = 0; init_left = 2; pend = 0; head_m = 0; tail_m = 0;
                exp_rv = 0; exp_err = 0; exp_wp = '0; exp_rp = '0;
                exp_q.delete(); sb_q.delete();
            end else begin
                acc = running && !bus.flush && bus.wr_valid && (exp_q.size() + int'(pend) < DEPTH);
                exp_rv = 0;
                exp_err = 0;
                if (!running) begin
                    exp_err = bus.rd_req;
                    init_left--;
                    if (init_left == 0) running = 1;
                end else if (bus.flush) begin
                    exp_q.delete(); sb_q.delete();
                    pend = 0; head_m = 0; tail_m = 0; exp_wp = '0; exp_rp = '0;
                    running = 0; init_left = 2;
                end else begin
                    if (bus.rd_req && exp_q.size() > 0) begin
                        sb_q.push_back(exp_q.pop_front());
                        exp_rp = address_t'(head_m);
                        head_m = (head_m + 1) % DEPTH;
                        exp_rv = 1;
                    end else exp_err = bus.rd_req;
                    if (pend) exp_q.push_back(pend_item);
                    pend = acc;
                    if (acc) begin
                        pend_item = '{opc: bus.wr_opcode, op_a: bus.wr_op_a, op_b: bus.wr_op_b,
                                      result: calc(bus.wr_opcode, bus.wr_op_a, bus.wr_op_b)};
                        exp_wp = address_t'(tail_m);
                        tail_m = (tail_m + 1) % DEPTH;
                    end
                end
            end
        end
    end

    // monitor: compares every status output, pops the scoreboard whenever rd_valid is shown
    initial forever begin
        @(negedge clk);
        chk("wr_ready", bus.wr_ready, running && !bus.flush && (exp_q.size() + int'(pend) < DEPTH));
        chk("count", bus.count, exp_q.size());
        chk("full", bus.full, exp_q.size() + int'(pend) == DEPTH);
        chk("empty", bus.empty, exp_q.size() == 0);
        chk("reg_reset_n", reg_reset_n, running);
        chk("load_en", load_en, pend);
        chk("write_pointer", write_pointer, exp_wp);
        chk("read_pointer", read_pointer, exp_rp);
        chk("rd_valid", bus.rd_valid, exp_rv);
        chk("rd_err", bus.rd_err, exp_err);
        if (pend) begin
            chk("opcode", opcode, pend_item.opc);
            chk("operand_a", operand_a, pend_item.op_a);
            chk("operand_b", operand_b, pend_item.op_b);
        end
        if (bus.rd_valid) begin
            if (sb_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", bus.rd_data, sb_q.pop_front());
            if (bus.rd_data.opc == ADD && bus.rd_data.op_a == 3 && bus.rd_data.op_b == 4)
                chk("add_result", bus.rd_data.result, 7);
        end
    end

    task automatic drive(bit wv, bit rq, bit fl, opcode_t o, operand_t a, operand_t b);
        @(posedge clk);
        #1;
        bus.wr_valid = wv;
        bus.rd_req = rq;
        bus.flush = fl;
        bus.wr_opcode = o;
        bus.wr_op_a = a;
        bus.wr_op_b = b;
    endtask

    task automatic step(bit wv, bit rq, bit fl);
        drive(wv, rq, fl, opcode_t'($urandom_range(0, 5)), operand_t'($urandom), operand_t'($urandom));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_reg_reset_n", reg_reset_n, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_opcode", opcode, ZERO);
        chk("rst_operands", {operand_a, operand_b}, 0);
        chk("rst_pointers", {write_pointer, read_pointer}, 0);
        bus.wr_valid = 0;
        bus.rd_req = 0;
        bus.flush = 0;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        bus.wr_valid = 0;
        bus.rd_req = 0;
        bus.flush = 0;
        bus.wr_opcode = ZERO;
        bus.wr_op_a = 0;
        bus.wr_op_b = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (4) step(0, 1, 0);
        step(0, 0, 0);
        drive(1, 0, 0, ADD, 3, 4);
        repeat (2) step(0, 0, 0);
        step(0, 1, 0);
        repeat (2) step(0, 0, 0);
        repeat (35) step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        repeat (34) step(0, 1, 0);
        step(0, 0, 0);
        repeat (5) step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        repeat (40) step(1, 1, 0);
        repeat (2) step(0, 0, 0);
        repeat (8) step(0, 1, 0);
        repeat (10) step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 1);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        repeat (400) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        repeat (3) step(1, 1, 0);
        mid_reset();
        repeat (4) step(0, 0, 0);
        repeat (100) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        repeat (40) step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
